// File: rtl/ins_mem_pkg.sv
// Shared constants, word type and default program image for the instruction memory.
package ins_mem_pkg;

  localparam int ADDR_W = 4;
  localparam int INS_W  = 9;
  localparam int DEPTH  = 16;

  typedef logic [INS_W-1:0] ins_t;

  localparam ins_t NOP = 9'h000;

  // Word i of the power-on program is simply i.
  localparam ins_t DEFAULT_IMAGE [DEPTH] = '{
    9'h000, 9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006, 9'h007,
    9'h008, 9'h009, 9'h00A, 9'h00B, 9'h00C, 9'h00D, 9'h00E, 9'h00F
  };

endpackage

// File: rtl/ins_mem_rd_mux.sv
// Combinational read mux: selects mem[rd_addr], zeroes out-of-range reads and
// forwards a same-edge write to the same address.
module ins_mem_rd_mux #(
  parameter int ADDR_W = 4,
  parameter int INS_W  = 9,
  parameter int DEPTH  = 16
) (
  input  logic [INS_W-1:0]  mem [DEPTH],
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INS_W-1:0]  wdata,
  output logic [INS_W-1:0]  rd_data
);

  logic in_range;

  assign in_range = int'(rd_addr) < DEPTH;

  always_comb begin
    rd_data = '0;
    if (in_range) begin
      if (we && (waddr == rd_addr)) begin
        rd_data = wdata;
      end else begin
        rd_data = mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/ins_mem_unit.sv
// 16 x 9 instruction memory: flop storage restored to the default image on reset,
// synchronous write port and a registered, write-first read at PC.
module ins_mem_unit
  import ins_mem_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] PC,
  output logic [INS_W-1:0]  RES_INS,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [INS_W-1:0]  WDATA
);

  ins_t             mem_reg [DEPTH];
  ins_t             rd_next;
  logic [DEPTH-1:0] wr_sel;

  // Addresses at or beyond DEPTH match no entry, so such writes drop out here.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
    assign wr_sel[gi] = WE && (WADDR == ADDR_W'(gi));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= DEFAULT_IMAGE[i];
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          mem_reg[i] <= WDATA;
        end
      end
    end
  end

  ins_mem_rd_mux #(
    .ADDR_W (ADDR_W),
    .INS_W  (INS_W),
    .DEPTH  (DEPTH)
  ) u_rd_mux (
    .mem     (mem_reg),
    .rd_addr (PC),
    .we      (WE),
    .waddr   (WADDR),
    .wdata   (WDATA),
    .rd_data (rd_next)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RES_INS <= NOP;
    end else begin
      RES_INS <= rd_next;
    end
  end

endmodule

// File: tb/tb_ins_mem_unit.sv
// Directed and randomized bench for ins_mem_unit against an array model of the
// program memory.
module tb_ins_mem_unit;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b1;
  logic [3:0] PC    = 4'h5;
  logic [8:0] RES_INS;
  logic       WE    = 1'b0;
  logic [3:0] WADDR = 4'h0;
  logic [8:0] WDATA = 9'h000;

  int checks = 0;
  int errors = 0;

  logic [8:0] model [16];

  always #5 CLK = ~CLK;

  ins_mem_unit dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .PC      (PC),
    .RES_INS (RES_INS),
    .WE      (WE),
    .WADDR   (WADDR),
    .WDATA   (WDATA)
  );

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 16; i++) model[i] = 9'(i);
  endtask

  // Called just after a falling edge: drive, take one rising edge, check at the
  // next falling edge, then commit the write to the model.
  task automatic do_cycle(input string tag, input logic [3:0] pc, input logic we,
                          input logic [3:0] waddr, input logic [8:0] wdata);
    logic [8:0] exp;
    PC = pc; WE = we; WADDR = waddr; WDATA = wdata;
    exp = (we && waddr == pc) ? wdata : model[pc];
    @(posedge CLK);
    @(negedge CLK);
    check(tag, RES_INS, exp);
    if (we) model[waddr] = wdata;
    $display("cycle %s pc=%h we=%0d waddr=%h wdata=%h res=%h exp=%h",
             tag, pc, we, waddr, wdata, RES_INS, exp);
  endtask

  initial begin
    // 1: asynchronous reset with no clock edge
    #1 RST_N = 1'b0;
    #1 check("rst_async", RES_INS, 9'h000);
    reset_model();
    @(negedge CLK);
    @(negedge CLK);
    check("rst_hold", RES_INS, 9'h000);
    RST_N = 1'b1;

    // 2: default image sweep
    for (int i = 0; i < 16; i++) do_cycle("sweep", 4'(i), 1'b0, 4'h0, 9'h000);

    // 3: write then read back, neighbour untouched
    do_cycle("wr3", 4'h0, 1'b1, 4'h3, 9'h1A5);
    do_cycle("rd3", 4'h3, 1'b0, 4'h0, 9'h000);
    do_cycle("rd4", 4'h4, 1'b0, 4'h0, 9'h000);

    // 4: same-edge write-first
    do_cycle("wfirst", 4'hA, 1'b1, 4'hA, 9'h0F0);
    do_cycle("rdA", 4'hA, 1'b0, 4'h0, 9'h000);

    // 5: overwrite 7, then mid-cycle reset with a write pending
    do_cycle("wr7", 4'h7, 1'b1, 4'h7, 9'h1FF);
    do_cycle("rd7", 4'h7, 1'b0, 4'h0, 9'h000);
    PC = 4'h7; WE = 1'b1; WADDR = 4'h7; WDATA = 9'h1FF;
    #2 RST_N = 1'b0;
    #1 check("rst_mid", RES_INS, 9'h000);
    reset_model();
    @(negedge CLK);
    check("rst_over_wr", RES_INS, 9'h000);
    WE = 1'b0;
    RST_N = 1'b1;
    do_cycle("rd7_def", 4'h7, 1'b0, 4'h0, 9'h000);
    do_cycle("rd3_def", 4'h3, 1'b0, 4'h0, 9'h000);

    // 6: hold at the top address, then wrap
    for (int i = 0; i < 3; i++) do_cycle("holdF", 4'hF, 1'b0, 4'h0, 9'h000);
    do_cycle("wrap0", 4'h0, 1'b0, 4'h0, 9'h000);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      do_cycle("rand", 4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
               4'($urandom_range(0, 15)), 9'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
